h10_mem_arb: RTL and testbench

//  Arbitrates the single-port core memory (4K x 16, synchronous) between the HITAC-10 CPU and a

---
 rtl/h10_mem_arb.sv | 137 +++++++++++++
 tb/tb_h10_mem_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h10_mem_arb.sv
// HITAC-10 core memory arbiter: CPU/secondary-master arbitration with starvation guard,
// issue/wait/ack sequencing and sticky out-of-range address trap.
module h10_mem_arb #(
    parameter int unsigned MEM_AW     = 12,
    parameter int unsigned DW         = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [14:0]       c_addr,
    input  logic [DW-1:0]     c_wdata,
    output logic              c_ack,
    output logic [DW-1:0]     c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [14:0]       d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,
    output logic [MEM_AW-1:0] m_addr,
    output logic              m_wren,
    output logic [DW-1:0]     m_wdata,
    input  logic [DW-1:0]     m_rdata,
    output logic              adr_err,
    input  logic              err_clr,
    output logic              busy
);

    localparam int unsigned SCW = $clog2(STARVE_MAX + 1);
    localparam int unsigned WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t             state_q, state_d;
    logic               gnt_d_q;
    logic               we_q;
    logic               oor_q;
    logic [MEM_AW-1:0]  addr_q;
    logic [DW-1:0]      wdata_q;
    logic [SCW-1:0]     starve_cnt;
    logic [WCW-1:0]     wait_cnt;

    logic               any_req;
    logic               starve_sat;
    logic               sel_d;
    logic               sel_we;
    logic [14:0]        sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               wait_last;

    assign any_req    = c_req | d_req;
    assign starve_sat = (starve_cnt == SCW'(STARVE_MAX));
    assign sel_d      = d_req & (~c_req | starve_sat);
    assign sel_we     = sel_d ? d_we    : c_we;
    assign sel_addr   = sel_d ? d_addr  : c_addr;
    assign sel_wdata  = sel_d ? d_wdata : c_wdata;
    assign wait_last  = (wait_cnt == WCW'(MEM_LAT - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_last) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        m_wren  = (state_q == S_ISSUE) & we_q & ~oor_q;
        c_ack   = (state_q == S_ACK) & ~gnt_d_q;
        d_ack   = (state_q == S_ACK) &  gnt_d_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
    end

    // Address is held past ISSUE so the memory sees it for the whole read latency;
    // read data is captured on the last WAIT edge so rdata is valid alongside ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_d_q    <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            c_rdata    <= '0;
            d_rdata    <= '0;
            adr_err    <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (any_req) begin
                    gnt_d_q <= sel_d;
                    we_q    <= sel_we;
                    oor_q   <= (sel_addr[14:MEM_AW] != '0);
                    addr_q  <= sel_addr[MEM_AW-1:0];
                    wdata_q <= sel_wdata;
                end
                if (!d_req || sel_d)
                    starve_cnt <= '0;
                else if (!starve_sat)
                    starve_cnt <= starve_cnt + SCW'(1);
            end

            if (state_q == S_ISSUE)
                wait_cnt <= '0;
            else if (state_q == S_WAIT)
                wait_cnt <= wait_cnt + WCW'(1);

            if (state_q == S_WAIT && wait_last) begin
                if (gnt_d_q)
                    d_rdata <= oor_q ? '0 : m_rdata;
                else
                    c_rdata <= oor_q ? '0 : m_rdata;
            end

            if (state_q == S_ACK && oor_q)
                adr_err <= 1'b1;
            else if (err_clr)
                adr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_h10_mem_arb.sv
// Directed self-checking bench for h10_mem_arb: default build (MEM_LAT=1) plus a MEM_LAT=3 build.
module tb_h10_mem_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // default-latency instance
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0, err_clr = 0;
    logic [14:0] c_addr = '0, d_addr = '0;
    logic [15:0] c_wdata = '0, d_wdata = '0;
    logic        c_ack, d_ack, m_wren, adr_err, busy;
    logic [15:0] c_rdata, d_rdata, m_wdata, m_rdata;
    logic [11:0] m_addr;

    // MEM_LAT=3 instance
    logic        b_c_req = 0, b_d_req = 0;
    logic [14:0] b_c_addr = '0, b_d_addr = '0;
    logic        b_c_ack, b_d_ack, b_m_wren, b_adr_err, b_busy;
    logic [15:0] b_c_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
    logic [11:0] b_m_addr;

    // preload port into both memory models
    logic        pl_en = 0;
    logic [11:0] pl_addr = '0;
    logic [15:0] pl_data = '0;

    h10_mem_arb u_dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wren(m_wren), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .adr_err(adr_err), .err_clr(err_clr), .busy(busy)
    );

    h10_mem_arb #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .c_req(b_c_req), .c_we(1'b0), .c_addr(b_c_addr), .c_wdata(16'h0000),
        .c_ack(b_c_ack), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata(16'h0000),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .m_addr(b_m_addr), .m_wren(b_m_wren), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata),
        .adr_err(b_adr_err), .err_clr(1'b0), .busy(b_busy)
    );

    logic [15:0] mem0 [0:4095];
    logic [15:0] mem1 [0:4095];
    logic [15:0] rp0, rp1_0, rp1_1, rp1_2;
    int          wren_cnt = 0;
    logic [11:0] last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;

    always @(posedge clk) begin
        if (pl_en)
            mem0[pl_addr] <= pl_data;
        else if (m_wren)
            mem0[m_addr] <= m_wdata;
        rp0 <= mem0[m_addr];
        if (m_wren) begin
            wren_cnt     <= wren_cnt + 1;
            last_wr_addr <= m_addr;
            last_wr_data <= m_wdata;
        end
    end
    assign m_rdata = rp0;

    always @(posedge clk) begin
        if (pl_en)
            mem1[pl_addr] <= pl_data;
        else if (b_m_wren)
            mem1[b_m_addr] <= b_m_wdata;
        rp1_0 <= mem1[b_m_addr];
        rp1_1 <= rp1_0;
        rp1_2 <= rp1_1;
    end
    assign b_m_rdata = rp1_2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cpu(input logic we, input logic [14:0] a, input logic [15:0] wd,
                           output int lat);
        c_we = we; c_addr = a; c_wdata = wd; c_req = 1'b1; lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            tick();
            if (c_ack) begin lat = i; c_req = 1'b0; end
        end
        c_req = 1'b0;
    endtask

    task automatic run_sec(input logic we, input logic [14:0] a, input logic [15:0] wd,
                           output int lat);
        d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1; lat = 0;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            tick();
            if (d_ack) begin lat = i; d_req = 1'b0; end
        end
        d_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pl_en = 1'b1;
        pl_addr = 12'h005; pl_data = 16'h7024; tick();
        pl_addr = 12'h0AB; pl_data = 16'hCAFE; tick();
        pl_addr = 12'h0AC; pl_data = 16'h5A5A; tick();
        pl_en = 1'b0;
        n_checks++; if ({c_ack, d_ack, m_wren, busy, adr_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {c_ack, d_ack, m_wren, busy, adr_err});
        end
        n_checks++; if (m_addr !== 12'h000 || m_wdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_mbus: got addr %h data %h expected 000 0000", m_addr, m_wdata);
        end
        n_checks++; if (c_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h expected 0000 0000", c_rdata, d_rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        int   lat = 0;
        logic dseen = 1'b0;
        logic [3:1] bv = '0;
        c_we = 1'b0; c_addr = 15'h0005; c_req = 1'b1;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (i <= 3) bv[i] = busy;
            if (d_ack) dseen = 1'b1;
            if (c_ack) begin lat = i; c_req = 1'b0; end
        end
        c_req = 1'b0;
        n_checks++; if (lat !== 3) begin
            n_fail++; $display("FAIL read_latency: got %0d expected 3", lat);
        end
        n_checks++; if (c_rdata !== 16'h7024) begin
            n_fail++; $display("FAIL read_data: got %h expected 7024", c_rdata);
        end
        n_checks++; if (dseen !== 1'b0) begin
            n_fail++; $display("FAIL read_no_dack: got %b expected 0", dseen);
        end
        n_checks++; if (bv !== 3'b111) begin
            n_fail++; $display("FAIL read_busy: got %b expected 111", bv);
        end
        tick();
        n_checks++; if (busy !== 1'b0) begin
            n_fail++; $display("FAIL read_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_sec_write();
        int lat;
        int wb = wren_cnt;
        run_sec(1'b1, 15'h0123, 16'hBEEF, lat);
        n_checks++; if (lat !== 3) begin
            n_fail++; $display("FAIL sec_wr_latency: got %0d expected 3", lat);
        end
        n_checks++; if (wren_cnt - wb !== 1) begin
            n_fail++; $display("FAIL sec_wr_pulses: got %0d expected 1", wren_cnt - wb);
        end
        n_checks++; if (last_wr_addr !== 12'h123 || last_wr_data !== 16'hBEEF) begin
            n_fail++; $display("FAIL sec_wr_bus: got %h %h expected 123 beef", last_wr_addr, last_wr_data);
        end
        tick();
        run_cpu(1'b0, 15'h0123, 16'h0000, lat);
        n_checks++; if (lat !== 3 || c_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL sec_wr_readback: got lat %0d data %h expected 3 beef", lat, c_rdata);
        end
        tick();
    endtask

    task automatic test_grant_order();
        logic [9:0] got = '0;
        int         overlap = 0;
        int         tmo = 0;
        c_we = 1'b0; c_addr = 15'h0005;
        d_we = 1'b0; d_addr = 15'h0123;
        c_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                tick();
                if (c_ack && d_ack) overlap++;
                if (c_ack || d_ack) begin seen = 1'b1; got[9-k] = d_ack; end
            end
            if (!seen) tmo++;
        end
        c_req = 1'b0; d_req = 1'b0;
        tick();
        n_checks++; if (got !== 10'b0000100001 || tmo != 0) begin
            n_fail++; $display("FAIL grant_order: got %b (timeouts %0d) expected 0000100001", got, tmo);
        end
        n_checks++; if (overlap != 0) begin
            n_fail++; $display("FAIL grant_overlap: got %0d expected 0", overlap);
        end
        n_checks++; if (c_rdata !== 16'h7024 || d_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL grant_data: got %h %h expected 7024 beef", c_rdata, d_rdata);
        end
    endtask

    task automatic test_addr_err();
        int lat;
        int wb = wren_cnt;
        run_cpu(1'b1, 15'h1005, 16'h1234, lat);
        n_checks++; if (lat !== 3) begin
            n_fail++; $display("FAIL oor_ack: got latency %0d expected 3", lat);
        end
        tick();
        n_checks++; if (wren_cnt !== wb) begin
            n_fail++; $display("FAIL oor_wren: got %0d pulses expected 0", wren_cnt - wb);
        end
        n_checks++; if (adr_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_set: got adr_err %b expected 1", adr_err);
        end
        n_checks++; if (mem0[12'h005] !== 16'h7024) begin
            n_fail++; $display("FAIL oor_mem: got %h expected 7024", mem0[12'h005]);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++; if (adr_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clr: got adr_err %b expected 0", adr_err);
        end
        run_cpu(1'b0, 15'h7000, 16'h0000, lat);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_checks++; if (adr_err !== 1'b1) begin
            n_fail++; $display("FAIL set_wins: got adr_err %b expected 1", adr_err);
        end
        n_checks++; if (lat !== 3 || c_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL oor_rdata: got lat %0d data %h expected 3 0000", lat, c_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        run_cpu(1'b0, 15'h0005, 16'h0000, lat);
        tick();
        c_we = 1'b0; c_addr = 15'h0005; c_req = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({c_ack, d_ack, m_wren, busy, adr_err} !== 5'b0) begin
            n_fail++; $display("FAIL midreset_ctl: got %b expected 00000", {c_ack, d_ack, m_wren, busy, adr_err});
        end
        n_checks++; if (m_addr !== 12'h000 || c_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL midreset_regs: got %h %h %h expected 000 0000 0000", m_addr, c_rdata, d_rdata);
        end
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            tick();
            if (c_ack) begin lat = i; c_req = 1'b0; end
        end
        c_req = 1'b0;
        n_checks++; if (lat !== 3 || c_rdata !== 16'h7024) begin
            n_fail++; $display("FAIL midreset_restart: got lat %0d data %h expected 3 7024", lat, c_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int c_at = 0;
        int d_at = 0;
        int overlap = 0;
        b_c_addr = 15'h00AB; b_c_req = 1'b1;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            tick();
            if (b_c_ack) begin lat = i; b_c_req = 1'b0; end
        end
        b_c_req = 1'b0;
        n_checks++; if (lat !== 5 || b_c_rdata !== 16'hCAFE) begin
            n_fail++; $display("FAIL lat3_read: got lat %0d data %h expected 5 cafe", lat, b_c_rdata);
        end
        tick();
        b_c_addr = 15'h00AB; b_d_addr = 15'h00AC;
        b_c_req = 1'b1; b_d_req = 1'b1;
        for (int i = 1; i <= 20 && d_at == 0; i++) begin
            tick();
            if (b_c_ack && b_d_ack) overlap++;
            if (b_c_ack) begin c_at = i; b_c_req = 1'b0; end
            if (b_d_ack) begin d_at = i; b_d_req = 1'b0; end
        end
        b_c_req = 1'b0; b_d_req = 1'b0;
        n_checks++; if (c_at !== 5 || d_at !== 11 || overlap != 0) begin
            n_fail++; $display("FAIL lat3_b2b: got c %0d d %0d overlap %0d expected 5 11 0", c_at, d_at, overlap);
        end
        n_checks++; if (b_c_rdata !== 16'hCAFE || b_d_rdata !== 16'h5A5A) begin
            n_fail++; $display("FAIL lat3_b2b_data: got %h %h expected cafe 5a5a", b_c_rdata, b_d_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_sec_write();
        test_grant_order();
        test_addr_err();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
